// File: rtl/perceptron_trainer.sv
// Purpose : sequential perceptron learning-rule trainer for a 2-input, 4-sample set (Q3.12).
// Latency : 2 cycles per sample (CALC, UPDATE) + 1 CHECK cycle per epoch; done at 9*N cycles after start.
// Backpressure: none; start is honoured only in IDLE or DONE and ignored while busy.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               begin a run (latches in1/in2/d and w*_init)
//   in1, in2, d         per-sample x1, x2 and target (target = d > 0)
//   w0_init..w2_init    initial weights; w0 is the bias weight
//   w0..w2              current weights
//   busy, done          run in progress / run finished
//   converged           last epoch had zero errors (valid with done)
//   epoch, err_count    epochs executed / misclassifications in current epoch
module perceptron_trainer #(
    parameter int             tam       = 16,
    parameter int             MAX_EPOCH = 15,
    parameter logic [tam-1:0] ETA       = 16'h0400
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [3:0][tam-1:0] in1,
    input  logic [3:0][tam-1:0] in2,
    input  logic [3:0][tam-1:0] d,
    input  logic [tam-1:0]      w0_init,
    input  logic [tam-1:0]      w1_init,
    input  logic [tam-1:0]      w2_init,
    output logic [tam-1:0]      w0,
    output logic [tam-1:0]      w1,
    output logic [tam-1:0]      w2,
    output logic                busy,
    output logic                done,
    output logic                converged,
    output logic [3:0]          epoch,
    output logic [2:0]          err_count
);

    localparam int FRAC    = 12;
    localparam int SAT_MAX = (1 << (tam - 1)) - 1;
    localparam int SAT_MIN = -(1 << (tam - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_UPDATE,
        S_CHECK,
        S_DONE
    } state_t;

    // Sign-extend a word to 32 bits so sums and products cannot wrap before saturation.
    function automatic logic signed [31:0] sx(input logic [tam-1:0] a);
        return {{(32 - tam){a[tam-1]}}, a};
    endfunction

    function automatic logic [tam-1:0] sat(input logic signed [31:0] x);
        logic [tam-1:0] r;
        if (x > SAT_MAX) begin
            r = {1'b0, {(tam - 1){1'b1}}};
        end else if (x < SAT_MIN) begin
            r = {1'b1, {(tam - 1){1'b0}}};
        end else begin
            r = x[tam-1:0];
        end
        return r;
    endfunction

    function automatic logic [tam-1:0] sat_add(input logic [tam-1:0] a, input logic [tam-1:0] b);
        return sat(sx(a) + sx(b));
    endfunction

    function automatic logic [tam-1:0] sat_sub(input logic [tam-1:0] a, input logic [tam-1:0] b);
        return sat(sx(a) - sx(b));
    endfunction

    // Full product of two Q3.12 values fits in 32 bits; rescale then clamp.
    function automatic logic [tam-1:0] sat_mul(input logic [tam-1:0] a, input logic [tam-1:0] b);
        logic signed [31:0] p;
        p = sx(a) * sx(b);
        return sat(p >>> FRAC);
    endfunction

    state_t                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [tam-1:0]        v_q, v_d;
    logic [tam-1:0]        w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
    logic [3:0]            epoch_q, epoch_d;
    logic [2:0]            err_q, err_d;
    logic                  conv_q, conv_d;
    logic [3:0][tam-1:0]   x1_q, x1_d, x2_q, x2_d;
    logic [3:0]            tgt_q, tgt_d;

    logic [tam-1:0]        x1_cur, x2_cur;
    logic [tam-1:0]        v_calc;
    logic [tam-1:0]        dw1, dw2;
    logic                  y_cur, t_cur;
    logic [3:0]            epoch_inc;

    assign x1_cur    = x1_q[idx_q];
    assign x2_cur    = x2_q[idx_q];
    // Each partial sum of v clamps independently.
    assign v_calc    = sat_add(sat_add(w0_q, sat_mul(w1_q, x1_cur)), sat_mul(w2_q, x2_cur));
    assign dw1       = sat_mul(ETA, x1_cur);
    assign dw2       = sat_mul(ETA, x2_cur);
    assign y_cur     = ~v_q[tam-1];     // v == 0 classifies as 1
    assign t_cur     = tgt_q[idx_q];
    assign epoch_inc = epoch_q + 4'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        v_d     = v_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        epoch_d = epoch_q;
        err_d   = err_q;
        conv_d  = conv_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        tgt_d   = tgt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    x1_d = in1;
                    x2_d = in2;
                    for (int k = 0; k < 4; k++) begin
                        tgt_d[k] = ~d[k][tam-1] & (|d[k]);
                    end
                    w0_d    = w0_init;
                    w1_d    = w1_init;
                    w2_d    = w2_init;
                    epoch_d = 4'd0;
                    err_d   = 3'd0;
                    conv_d  = 1'b0;
                    idx_d   = 2'd0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                v_d     = v_calc;
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                // err = t - y: +1 when t=1,y=0; -1 when t=0,y=1.
                if (t_cur & ~y_cur) begin
                    err_d = err_q + 3'd1;
                    w0_d  = sat_add(w0_q, ETA);
                    w1_d  = sat_add(w1_q, dw1);
                    w2_d  = sat_add(w2_q, dw2);
                end else if (~t_cur & y_cur) begin
                    err_d = err_q + 3'd1;
                    w0_d  = sat_sub(w0_q, ETA);
                    w1_d  = sat_sub(w1_q, dw1);
                    w2_d  = sat_sub(w2_q, dw2);
                end
                if (idx_q == 2'd3) begin
                    state_d = S_CHECK;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_CALC;
                end
            end
            S_CHECK: begin
                epoch_d = epoch_inc;
                if (err_q == 3'd0) begin
                    conv_d  = 1'b1;
                    state_d = S_DONE;
                end else if (epoch_inc == 4'(MAX_EPOCH)) begin
                    conv_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = 2'd0;
                    err_d   = 3'd0;
                    state_d = S_CALC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            v_q     <= '0;
            w0_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            epoch_q <= '0;
            err_q   <= '0;
            conv_q  <= 1'b0;
            x1_q    <= '0;
            x2_q    <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            v_q     <= v_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            epoch_q <= epoch_d;
            err_q   <= err_d;
            conv_q  <= conv_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            tgt_q   <= tgt_d;
        end
    end

    assign w0        = w0_q;
    assign w1        = w1_q;
    assign w2        = w2_q;
    assign busy      = (state_q == S_CALC) || (state_q == S_UPDATE) || (state_q == S_CHECK);
    assign done      = (state_q == S_DONE);
    assign converged = conv_q;
    assign epoch     = epoch_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
module tb_perceptron_trainer;

    typedef struct {
        int          lat;
        logic        conv;
        logic [3:0]  ep;
        logic        chk_w;
        logic [15:0] w0, w1, w2;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tot = 0;
    int n_bad = 0;

    exp_t q_main[$];
    exp_t q_sat[$];

    // Main DUT: default ETA
    logic             start = 1'b0;
    logic [3:0][15:0] in1, in2, d;
    logic [15:0]      w0_init, w1_init, w2_init;
    logic [15:0]      w0, w1, w2;
    logic             busy, done, converged;
    logic [3:0]       epoch;
    logic [2:0]       err_count;

    perceptron_trainer u_dut (
        .clk(clk), .rst(rst), .start(start),
        .in1(in1), .in2(in2), .d(d),
        .w0_init(w0_init), .w1_init(w1_init), .w2_init(w2_init),
        .w0(w0), .w1(w1), .w2(w2),
        .busy(busy), .done(done), .converged(converged),
        .epoch(epoch), .err_count(err_count)
    );

    // Saturation DUT: ETA = 1.0
    logic             s_start = 1'b0;
    logic [3:0][15:0] s_in1, s_in2, s_d;
    logic [15:0]      s_w0_init, s_w1_init, s_w2_init;
    logic [15:0]      s_w0, s_w1, s_w2;
    logic             s_busy, s_done, s_converged;
    logic [3:0]       s_epoch;
    logic [2:0]       s_err_count;

    perceptron_trainer #(.tam(16), .MAX_EPOCH(15), .ETA(16'h1000)) u_sat (
        .clk(clk), .rst(rst), .start(s_start),
        .in1(s_in1), .in2(s_in2), .d(s_d),
        .w0_init(s_w0_init), .w1_init(s_w1_init), .w2_init(s_w2_init),
        .w0(s_w0), .w1(s_w1), .w2(s_w2),
        .busy(s_busy), .done(s_done), .converged(s_converged),
        .epoch(s_epoch), .err_count(s_err_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_result(input string tag, input exp_t e, input logic cv, input logic [3:0] ep,
                                input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
        chk({tag, "_latency"}, cyc - e.acc, e.lat);
        chk({tag, "_converged"}, {31'd0, cv}, {31'd0, e.conv});
        chk({tag, "_epoch"}, {28'd0, ep}, {28'd0, e.ep});
        if (e.chk_w) begin
            chk({tag, "_w0"}, {16'd0, a0}, {16'd0, e.w0});
            chk({tag, "_w1"}, {16'd0, a1}, {16'd0, e.w1});
            chk({tag, "_w2"}, {16'd0, a2}, {16'd0, e.w2});
        end
    endtask

    // Monitors: a rising done is the DUT's result event.
    logic done_prev = 1'b0;
    logic s_done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_prev) begin
            if (q_main.size() == 0) begin
                chk("main_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q_main.pop_front();
                check_result("main", e, converged, epoch, w0, w1, w2);
            end
        end
        done_prev = done;
    end

    always @(negedge clk) begin
        exp_t e;
        if (s_done && !s_done_prev) begin
            if (q_sat.size() == 0) begin
                chk("sat_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q_sat.pop_front();
                check_result("sat", e, s_converged, s_epoch, s_w0, s_w1, s_w2);
            end
        end
        s_done_prev = s_done;
    end

    function automatic exp_t or_exp();
        exp_t e;
        e.lat = 27; e.conv = 1'b1; e.ep = 4'd3; e.chk_w = 1'b1;
        e.w0 = 16'hFC00; e.w1 = 16'h0400; e.w2 = 16'h0400; e.acc = 0;
        return e;
    endfunction

    task automatic set_or();
        in1 = {16'h0000, 16'h1000, 16'h0000, 16'h1000};
        in2 = {16'h0000, 16'h0000, 16'h1000, 16'h1000};
        d   = {16'h0000, 16'h1000, 16'h1000, 16'h1000};
        w0_init = 16'h0; w1_init = 16'h0; w2_init = 16'h0;
    endtask

    // Issues a one-cycle start; returns at the negedge after the accepting edge.
    task automatic do_start(input logic push, input exp_t e);
        exp_t x;
        x = e;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x.acc = cyc;
        if (push) q_main.push_back(x);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q_main.size() != 0 || q_sat.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {31'd0, (n >= 400)}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        set_or();
        s_in1 = {4{16'h1000}};
        s_in2 = {4{16'h0000}};
        s_d   = {4{16'h1000}};
        s_w0_init = 16'h8000; s_w1_init = 16'h7F00; s_w2_init = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_w", {w0, w1}, 32'd0);
        chk("rst_w2_epoch_err", {9'd0, w2, epoch, err_count}, 32'd0);
        chk("rst_converged", {31'd0, converged}, 32'd0);
        chk("rst_sat_w", {s_w0, s_w1}, 32'd0);
        rst = 1'b0;

        // OR set from idle
        do_start(1'b1, or_exp());
        chk("or_busy_after_start", {31'd0, busy}, 32'd1);
        wait_drain();

        // Restart from DONE: fresh run, epoch cleared on the accepting edge
        chk("done_before_restart", {31'd0, done}, 32'd1);
        do_start(1'b1, or_exp());
        chk("restart_done_low", {31'd0, done}, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        chk("restart_epoch", {28'd0, epoch}, 32'd0);
        wait_drain();

        // Reset mid-run (cycle 10 of OR run)
        do_start(1'b0, or_exp());
        repeat (9) @(negedge clk);
        chk("mid_w0_before_rst", {16'd0, w0}, 32'h0000FC00);
        chk("mid_epoch_before_rst", {28'd0, epoch}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("mid_rst_w", {w0, w1}, 32'd0);
        chk("mid_rst_w2_epoch", {12'd0, w2, epoch}, 32'd0);
        rst = 1'b0;
        do_start(1'b1, or_exp());
        wait_drain();

        // Start pulses and input changes while busy are ignored
        do_start(1'b1, or_exp());
        for (int k = 0; k < 20; k++) begin
            start   = k[0];
            in1     = {$urandom, $urandom};
            in2     = {$urandom, $urandom};
            d       = {$urandom, $urandom};
            w0_init = 16'($urandom);
            w1_init = 16'($urandom);
            w2_init = 16'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        set_or();
        wait_drain();

        // XOR set never converges
        d = {16'h0000, 16'h1000, 16'h1000, 16'h0000};
        e.lat = 135; e.conv = 1'b0; e.ep = 4'd15; e.chk_w = 1'b0;
        e.w0 = 16'h0; e.w1 = 16'h0; e.w2 = 16'h0; e.acc = 0;
        do_start(1'b1, e);
        wait_drain();
        set_or();

        // Saturation with ETA = 1.0
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        e.lat = 18; e.conv = 1'b1; e.ep = 4'd2; e.chk_w = 1'b1;
        e.w0 = 16'h9000; e.w1 = 16'h7FFF; e.w2 = 16'h0000; e.acc = cyc;
        q_sat.push_back(e);
        @(negedge clk);
        chk("sat_w0_after_calc", {16'd0, s_w0}, 32'h00008000);
        @(negedge clk);
        chk("sat_w0_first_update", {16'd0, s_w0}, 32'h00009000);
        chk("sat_w1_first_update", {16'd0, s_w1}, 32'h00007FFF);
        wait_drain();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/perceptron_trainer.md
# perceptron_trainer

Sequential training stage for the 2-input perceptron datapath. It runs the perceptron learning rule over the same 4-sample training set that the inference stage evaluates, iterating epoch by epoch until one epoch completes with no misclassifications or the epoch limit is reached. Its w0/w1/w2 outputs drive the weight inputs of the fixed-point inference stage, which reads them only after `done`. All arithmetic is signed fixed-point Q3.12: sign bit, 3 integer bits, 12 fraction bits, so 1.0 = 16'h1000.

## Interface
- tam, 16: data and weight width; only 16 is supported.
- MAX_EPOCH, 15: epoch limit, 1..15.
- ETA, 16'h0400: learning rate in Q3.12; the default is 0.25.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a training run; sampled only in IDLE or DONE.
- in1  in  [3:0][tam-1:0]  x1 for samples 0..3.
- in2  in  [3:0][tam-1:0]  x2 for samples 0..3.
- d  in  [3:0][tam-1:0]  targets for samples 0..3; the target is 1 when d[i] is positive and nonzero, else 0.
- w0_init, w1_init, w2_init  in  tam  initial weights, loaded at start.
- w0, w1, w2  out  tam  current weights; w0 is the bias weight, applied to the constant input 1.0.
- busy  out  1  high while training.
- done  out  1  high in the DONE state.
- converged  out  1  valid while done is high; 1 means the last epoch had zero errors.
- epoch  out  4  number of epochs executed in the current or last run.
- err_count  out  3  misclassifications so far in the current epoch (0..4).

## Operation
- Reset values: state IDLE, all other outputs 0.
- When start is accepted:
  - in1, in2, d and the three w*_init inputs are latched into internal registers; later input changes have no effect on the run.
  - epoch is cleared, err_count is cleared, and the sample index i is set to 0.
- States:
  - IDLE: start → CALC.
  - CALC: registers v = w0 + w1·x1[i] + w2·x2[i] → UPDATE.
  - UPDATE: applies the weight update below. Then i<3 → CALC with i+1; i=3 → CHECK.
  - CHECK: epoch+1 is computed. If err_count==0 → DONE with converged=1. Else if epoch+1==MAX_EPOCH → DONE with converged=0. Else → CALC with i=0 and err_count cleared. epoch always takes the incremented value.
  - DONE: done=1 and weights hold; start → CALC as a fresh run.
- Multiply: a full 32-bit signed product, arithmetic shift right by 12, then saturate to [16'h8000, 16'h7FFF].
- Add: every addition saturates to the same range, including each partial sum of v.
- Classification:
  - y = 1 iff v[15]==0, so v = 0 classifies as 1.
  - err = t − y, which is one of {−1, 0, +1}.
- Update in UPDATE:
  - err==0: weights unchanged.
  - err≠0: err_count increments, and w0 ± ETA, w1 ± ETA·x1[i], w2 ± ETA·x2[i] are applied, each saturating. The sign is the sign of err.
- start while busy is ignored.
- rst at any cycle wins over everything: IDLE, all outputs 0, and the run is abandoned.

## Timing
- Each sample takes 2 cycles (CALC, UPDATE). Each epoch takes 9 cycles (4×2 + CHECK).
- busy rises on the edge that accepts start and falls on entry to DONE.
- A run of N epochs asserts done exactly 9·N cycles after the accepting edge.
- Weight outputs change only on UPDATE edges.
- Restart from DONE: done falls on the same edge that accepts start.

## Test plan
- OR set, defaults, w*_init=0:
  - Stimulus: in1={0,0x1000,0,0x1000}, in2={0,0,0x1000,0x1000}, d={0,0x1000,0x1000,0x1000} (listed [3]..[0]).
  - Required: done 27 cycles after start, converged=1, epoch=3, w0=0xFC00, w1=0x0400, w2=0x0400.
- XOR set (d={0,0x1000,0x1000,0}):
  - Required: done after 135 cycles, converged=0, epoch=15.
- Saturation:
  - Stimulus: all samples x1=0x1000, x2=0, d=0x1000; w0_init=0x8000, w1_init=0x7F00, w2_init=0; ETA=0x1000.
  - Required: w0=0x9000 and w1=0x7FFF after the first UPDATE, then converged=1, epoch=2.
- Reset mid-run: assert rst in cycle 10 of the OR run.
  - Required: the next cycle shows busy=0, done=0, w0=w1=w2=0, epoch=0.
  - A subsequent start reproduces the first scenario exactly.
- Start pulses and input changes while busy:
  - Required: ignored, with results identical to the first scenario.
  - Start in DONE: a fresh run with epoch reset to 0.
